ballot_controller: RTL and testbench
====================================

BALLOT_CONTROLLER -- requirements
Module: ballot_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 8: consecutive sampling edges a single button must be held to count as a vote.
REQ-002 SHALL have parameter ARM_TIMEOUT, default 255: cycles an armed ballot waits for a press before expiring (range 2..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mode  input  1  0 = voting, 1 = results; voting inhibited when 1.
REQ-006 SHALL have port arm  input  1  officer enable; level-sampled in IDLE.
REQ-007 SHALL have port button  input  4  candidate buttons, bit n = candidate n, synchronous to clk.
REQ-008 SHALL have port vote_valid  output  1  one-cycle pulse to tally datapath.
REQ-009 SHALL have port vote_id  output  2  candidate index, valid only while vote_valid=1, else 0.
REQ-010 SHALL have port spoiled  output  1  one-cycle pulse on multi-button press.
REQ-011 SHALL have port timeout  output  1  one-cycle pulse on armed-ballot expiry.
REQ-012 SHALL have port armed  output  1  high in ARMED and QUALIFY.
REQ-013 SHALL have port ballots  output  8  count of committed votes, saturating at 255.

Function
REQ-014 SHALL implement FSM states IDLE, ARMED, QUALIFY, COMMIT, RELEASE; all outputs registered.
REQ-015 IDLE -> ARMED SHALL occur when arm=1, mode=0 and button=4'b0000; otherwise remain IDLE; arm while any button held is ignored.
REQ-016 ARMED: exactly one button bit set -> capture its index, debounce count=1, go QUALIFY.
REQ-017 ARMED: two or more button bits set -> spoiled pulse next cycle, go RELEASE; no vote, ballots unchanged.
REQ-018 ARMED: armed-timer counts every cycle in ARMED/QUALIFY from entry; at ARM_TIMEOUT cycles -> timeout pulse, go IDLE; timer expiry has priority over press detection on the same edge.
REQ-019 QUALIFY: captured button alone still set -> count+1; count reaching DEBOUNCE -> go COMMIT.
REQ-020 QUALIFY: captured button released or any other bit set -> return ARMED, count cleared, armed-timer NOT cleared.
REQ-021 ARMED/QUALIFY: mode=1 -> go IDLE silently (no pulse), ballots unchanged.
REQ-022 COMMIT: vote_valid=1 and vote_id=captured index for exactly one cycle; ballots+1 unless already 255; then go RELEASE.
REQ-023 Latency: vote_valid SHALL be high in the cycle following the DEBOUNCE-th consecutive sampling edge of the held button.
REQ-024 RELEASE: stay until button=4'b0000, then go IDLE; a held button SHALL never produce a second vote; mode ignored.
REQ-025 Pulses vote_valid, spoiled, timeout SHALL be mutually exclusive.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, all counters 0, ballots=0, and every output 0, regardless of clk.
REQ-027 Reset mid-QUALIFY or mid-COMMIT SHALL discard the pending vote; first vote after release requires a new arm.

Structure
REQ-028 Package evm_pkg SHALL hold the state enum, candidate count (4), vote_id width (2), ballots width (8) and DEBOUNCE/ARM_TIMEOUT defaults.
REQ-029 One sub-module, evm_cycle_counter (clear, enable, terminal-count flag), SHALL be instantiated twice: debounce and armed-timer.

Verification
REQ-030 Reset, arm=1, button=0001 held 10 cycles -> single vote_valid, vote_id=0, DEBOUNCE+1 cycles after first sample; ballots=1.
REQ-031 Armed, button=0010 held 5 cycles then released, then held 10 -> no pulse after first press, then one vote_valid with vote_id=1; ballots+1.
REQ-032 Armed, button=0101 same cycle -> spoiled pulse, no vote_valid, ballots unchanged, armed=0 until release and re-arm.
REQ-033 ARM_TIMEOUT=50, arm, no press -> timeout pulse at cycle 50, armed=0; mode=1 during QUALIFY -> IDLE, no pulse.
REQ-034 button=1000 held 30 cycles -> exactly one vote_id=3; arm while held ignored; 256 total votes -> ballots stays 255.
REQ-035 reset asserted between clock edges during QUALIFY -> outputs 0 before next edge, ballots=0, no vote after deassert.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared types and constants for the ballot controller: FSM states, widths,
// default timing and small button-decoding helpers.
package evm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_QUALIFY,
    S_COMMIT,
    S_RELEASE
  } state_t;

  localparam int NUM_CAND        = 4;
  localparam int ID_W            = 2;
  localparam int BALLOT_W        = 8;
  localparam int DEBOUNCE_DEF    = 8;
  localparam int ARM_TIMEOUT_DEF = 255;

  localparam logic [BALLOT_W-1:0] BALLOT_MAX = {BALLOT_W{1'b1}};
  localparam logic [NUM_CAND-1:0] CAND_ONE   = {{(NUM_CAND-1){1'b0}}, 1'b1};

  // Index of the highest set bit; only meaningful for a one-hot input.
  function automatic logic [ID_W-1:0] onehot_index(input logic [NUM_CAND-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_press(input logic [NUM_CAND-1:0] v);
    return (v & (v - CAND_ONE)) != '0;
  endfunction

  function automatic logic single_press(input logic [NUM_CAND-1:0] v);
    return (v != '0) && !multi_press(v);
  endfunction

endpackage

// File: rtl/evm_cycle_counter.sv
// Up-counter with synchronous clear and a terminal-count flag at LIMIT-1.
// The count holds at the terminal value until cleared.
module evm_cycle_counter #(
  parameter int LIMIT = 8,
  parameter int WIDTH = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !tc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == LAST);

endmodule

// File: rtl/ballot_controller.sv
// Voting-machine front end: arms a ballot, debounces a single candidate button,
// and emits one registered vote/spoil/timeout pulse per ballot.
module ballot_controller
  import evm_pkg::*;
#(
  parameter int DEBOUNCE    = DEBOUNCE_DEF,
  parameter int ARM_TIMEOUT = ARM_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                arm,
  input  logic [NUM_CAND-1:0] button,
  output logic                vote_valid,
  output logic [ID_W-1:0]     vote_id,
  output logic                spoiled,
  output logic                timeout,
  output logic                armed,
  output logic [BALLOT_W-1:0] ballots
);

  state_t state_reg, state_next;
  logic [ID_W-1:0]     cand_reg;
  logic [NUM_CAND-1:0] cand_onehot;
  logic                single, multi, held_ok, busy;
  logic                deb_clear, deb_tc;
  logic                tmr_clear, tmr_enable, tmr_tc;

  logic                vote_valid_next, spoiled_next, timeout_next, armed_next;
  logic [ID_W-1:0]     vote_id_next;
  logic [BALLOT_W-1:0] ballots_next;

  assign single      = single_press(button);
  assign multi       = multi_press(button);
  assign cand_onehot = CAND_ONE << cand_reg;
  assign held_ok     = (button == cand_onehot);
  assign busy        = (state_reg == S_ARMED) || (state_reg == S_QUALIFY);

  // Debounce count is nonzero only while qualifying; the ARMED edge that
  // captures the button counts as the first sample.
  assign deb_clear = (state_next != S_QUALIFY);

  evm_cycle_counter #(.LIMIT(DEBOUNCE)) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .clear  (deb_clear),
    .enable (1'b1),
    .tc     (deb_tc)
  );

  // Armed timer runs across ARMED/QUALIFY bounces and only restarts from IDLE.
  assign tmr_enable = busy;
  assign tmr_clear  = !((state_next == S_ARMED) || (state_next == S_QUALIFY));

  evm_cycle_counter #(.LIMIT(ARM_TIMEOUT)) u_armed_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .tc     (tmr_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (arm && !mode && (button == '0)) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (mode)        state_next = S_IDLE;
        else if (tmr_tc) state_next = S_IDLE;
        else if (multi)  state_next = S_RELEASE;
        else if (single) state_next = deb_tc ? S_COMMIT : S_QUALIFY;
      end
      S_QUALIFY: begin
        if (mode)         state_next = S_IDLE;
        else if (tmr_tc)  state_next = S_IDLE;
        else if (held_ok) state_next = deb_tc ? S_COMMIT : S_QUALIFY;
        else              state_next = S_ARMED;
      end
      S_COMMIT: begin
        state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (button == '0) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    vote_valid_next = (state_next == S_COMMIT);
    vote_id_next    = '0;
    if (vote_valid_next) begin
      vote_id_next = (state_reg == S_ARMED) ? onehot_index(button) : cand_reg;
    end
    spoiled_next = (state_reg == S_ARMED) && (state_next == S_RELEASE);
    timeout_next = busy && !mode && tmr_tc;
    armed_next   = (state_next == S_ARMED) || (state_next == S_QUALIFY);
    ballots_next = ballots;
    if (vote_valid_next && (ballots != BALLOT_MAX)) begin
      ballots_next = ballots + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_reg <= '0;
    end else if ((state_reg == S_ARMED) && (state_next == S_QUALIFY)) begin
      cand_reg <= onehot_index(button);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vote_valid <= 1'b0;
      vote_id    <= '0;
      spoiled    <= 1'b0;
      timeout    <= 1'b0;
      armed      <= 1'b0;
      ballots    <= '0;
    end else begin
      vote_valid <= vote_valid_next;
      vote_id    <= vote_id_next;
      spoiled    <= spoiled_next;
      timeout    <= timeout_next;
      armed      <= armed_next;
      ballots    <= ballots_next;
    end
  end

endmodule

// File: tb/tb_ballot_controller.sv
// Scoreboard bench for ballot_controller: a ballot-level reference model
// predicts each cycle's response, a negedge monitor compares against the DUT.
module tb_ballot_controller;

  localparam int DEB = 8;
  localparam int TMO = 50;
  localparam int K_NONE = 0, K_VOTE = 1, K_SPOIL = 2, K_TMO = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       arm = 1'b0;
  logic [3:0] button = 4'b0000;
  logic       vote_valid, spoiled, timeout, armed;
  logic [1:0] vote_id;
  logic [7:0] ballots;

  ballot_controller #(.DEBOUNCE(DEB), .ARM_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .arm        (arm),
    .button     (button),
    .vote_valid (vote_valid),
    .vote_id    (vote_id),
    .spoiled    (spoiled),
    .timeout    (timeout),
    .armed      (armed),
    .ballots    (ballots)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         due;
    int         kind;
    logic [1:0] id;
    int         bal;
    int         arm_o;
  } exp_t;
  exp_t exp_q[$];

  // Ballot-level reference state
  int         m_armed, m_release, m_commit, m_age, m_run, m_ballots;
  logic [3:0] m_btn;

  function automatic void check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic model_clear();
    m_armed = 0; m_release = 0; m_commit = 0;
    m_age = 0; m_run = 0; m_btn = 4'b0000; m_ballots = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic m, input logic a, input logic [3:0] b);
    int kind;
    int nb;
    logic [1:0] id;
    exp_t e;
    kind = K_NONE;
    id = 2'd0;
    nb = $countones(b);
    for (int i = 0; i < 4; i++) if (b[i]) id = 2'(i);
    if (m_commit != 0) begin
      m_commit = 0;
      m_release = 1;
    end else if (m_release != 0) begin
      if (b == 4'b0000) m_release = 0;
    end else if (m_armed == 0) begin
      if (a && !m && b == 4'b0000) begin
        m_armed = 1; m_age = 0; m_run = 0;
      end
    end else begin
      m_age++;
      if (m) begin
        m_armed = 0;
      end else if (m_age == TMO) begin
        m_armed = 0;
        kind = K_TMO;
      end else if (nb >= 2 && m_run == 0) begin
        m_armed = 0; m_release = 1;
        kind = K_SPOIL;
      end else if (nb == 1 && (m_run == 0 || b == m_btn)) begin
        m_btn = b;
        m_run++;
        if (m_run == DEB) begin
          m_armed = 0; m_commit = 1;
          if (m_ballots < 255) m_ballots++;
          kind = K_VOTE;
        end
      end else begin
        m_run = 0;
      end
    end
    e.due = cyc + 1;
    e.kind = kind;
    e.id = id;
    e.bal = m_ballots;
    e.arm_o = m_armed;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic m, input logic a, input logic [3:0] b);
    @(posedge clk);
    #1;
    mode = m; arm = a; button = b;
    model_step(m, a, b);
  endtask

  task automatic vote(input logic [3:0] b, input int hold);
    cycle(1'b0, 1'b1, 4'b0000);
    repeat (hold) cycle(1'b0, 1'b0, b);
    cycle(1'b0, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 4'b0000);
  endtask

  task automatic do_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1; mode = 1'b0; arm = 1'b0; button = 4'b0000;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_vote_valid"}, int'(vote_valid), 0);
    check({tag, "_vote_id"}, int'(vote_id), 0);
    check({tag, "_spoiled"}, int'(spoiled), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_armed"}, int'(armed), 0);
    check({tag, "_ballots"}, int'(ballots), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check("vote_valid", int'(vote_valid), int'(e.kind == K_VOTE));
      check("spoiled", int'(spoiled), int'(e.kind == K_SPOIL));
      check("timeout", int'(timeout), int'(e.kind == K_TMO));
      check("vote_id", int'(vote_id), (e.kind == K_VOTE) ? int'(e.id) : 0);
      check("ballots", int'(ballots), e.bal);
      check("armed", int'(armed), e.arm_o);
    end else if (!reset) begin
      check("stray_pulse", int'(vote_valid | spoiled | timeout), 0);
    end
  end

  initial begin
    logic [3:0] b;
    int len;
    int r;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b0;

    // Single clean vote for candidate 0
    vote(4'b0001, 10);
    // Short press then release, then a full press for candidate 1
    cycle(1'b0, 1'b1, 4'b0000);
    repeat (5) cycle(1'b0, 1'b0, 4'b0010);
    cycle(1'b0, 1'b0, 4'b0000);
    repeat (10) cycle(1'b0, 1'b0, 4'b0010);
    repeat (2) cycle(1'b0, 1'b0, 4'b0000);
    // Two buttons together spoil; arm during release is ignored
    cycle(1'b0, 1'b1, 4'b0000);
    repeat (3) cycle(1'b0, 1'b0, 4'b0101);
    cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b0, 1'b0, 4'b0000);
    // Armed with no press expires
    cycle(1'b0, 1'b1, 4'b0000);
    repeat (55) cycle(1'b0, 1'b0, 4'b0000);
    // Results mode mid-qualify drops the ballot silently
    cycle(1'b0, 1'b1, 4'b0000);
    repeat (3) cycle(1'b0, 1'b0, 4'b0001);
    cycle(1'b1, 1'b0, 4'b0001);
    repeat (12) cycle(1'b0, 1'b0, 4'b0001);
    cycle(1'b0, 1'b0, 4'b0000);
    // Arm while held is ignored; long hold gives one vote
    repeat (3) cycle(1'b0, 1'b1, 4'b1000);
    cycle(1'b0, 1'b0, 4'b0000);
    vote(4'b1000, 30);

    // Random segments of held button patterns
    for (int s = 0; s < 250; s++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        b = 4'b0000;
      end else if (r < 75) begin
        b = 4'b0001 << $urandom_range(0, 3);
      end else begin
        b = 4'($urandom_range(0, 15));
        while ($countones(b) < 2) b = 4'($urandom_range(0, 15));
      end
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        cycle(1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 30), b);
      end
    end
    repeat (3) cycle(1'b0, 1'b0, 4'b0000);

    // Saturation of the ballot count
    do_reset();
    for (int v = 0; v < 260; v++) begin
      vote(4'b0001 << $urandom_range(0, 3), 9);
    end

    // Asynchronous reset between edges while qualifying
    cycle(1'b0, 1'b1, 4'b0000);
    repeat (4) cycle(1'b0, 1'b0, 4'b0100);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_clear();
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) cycle(1'b0, 1'b0, 4'b0100);
    repeat (3) cycle(1'b0, 1'b1, 4'b0100);
    cycle(1'b0, 1'b0, 4'b0000);
    vote(4'b0100, 10);

    repeat (3) cycle(1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
